// File: rtl/dec_scan_nw.sv
// Registered N-to-2^N one-hot decoder with a static mode and an autonomous
// scan mode that walks the output through slots 0..LAST, DWELL cycles each.
module dec_scan_nw #(
    parameter int SEL_W = 3,
    parameter int LAST  = 2**SEL_W - 1,
    parameter int DWELL = 1,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] y,
    output logic [SEL_W-1:0] idx,
    output logic             active,
    output logic             wrap
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STATIC,
        SCAN
    } state_e;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               active_q, active_d;
    logic               wrap_q, wrap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   startSlot;
    logic [SEL_W-1:0]   nextSlot;

    // A start slot beyond LAST falls back to 0; the explicit LAST compare
    // covers scan ranges that do not end on the natural SEL_W wrap.
    assign startSlot = (sel <= SEL_W'(LAST)) ? sel : '0;
    assign nextSlot  = (idx_q == SEL_W'(LAST)) ? '0 : idx_q + SEL_W'(1);

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        idx_d    = idx_q;
        active_d = active_q;
        wrap_d   = 1'b0;
        cnt_d    = cnt_q;
        if (!en) begin
            state_d  = IDLE;
            y_d      = '0;
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (!mode) begin
            state_d  = STATIC;
            y_d      = OUT_W'(1) << sel;
            idx_d    = sel;
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (start) begin
            state_d  = SCAN;
            y_d      = OUT_W'(1) << startSlot;
            idx_d    = startSlot;
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (state_q != SCAN) begin
            // Entering scan mode without a start pulse leaves the output dark.
            state_d  = IDLE;
            y_d      = '0;
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (cnt_q == CNT_W'(DWELL - 1)) begin
            cnt_d    = '0;
            idx_d    = nextSlot;
            y_d      = OUT_W'(1) << nextSlot;
            wrap_d   = (idx_q == SEL_W'(LAST));
        end else begin
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            y_q      <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
            wrap_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            wrap_q   <= wrap_d;
            cnt_q    <= cnt_d;
        end
    end

    assign y      = y_q;
    assign idx    = idx_q;
    assign active = active_q;
    assign wrap   = wrap_q;

endmodule
